shiftreg_lanes: RTL

- Parametrised multi-lane successor to the single-bit shift register.
- C independent N-bit lanes share one control path.
- Each lane supports parallel load, serial shift with serial insert, and a runtime-selectable tap length.
- A step counter with busy/done status lets the bit-serial datapath serialise one word per lane, MSB first, and know when the word is exhausted.

---
 rtl/shiftreg_lanes.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/shiftreg_lanes.sv
// ---------------------------------------------------------------------------
// shiftreg_lanes
//
// C independent N-bit shift-register lanes driven by one shared control path.
// Every lane can be parallel-loaded, shifted left with a per-lane serial insert
// bit, and tapped at a runtime-selected length. A shared step counter tracks
// how many bits of the loaded word remain, so a bit-serial consumer can pull
// one word per lane MSB first and learn exactly when that word is exhausted.
//
// Optional feature (compile-time macro):
//   SHIFTREG_LANES_PAROUT_EN  adds the dout port that exposes every lane
//                             register in parallel (deserialising path).
//
// Parameters:
//   N   bits per lane (N >= 1)
//   C   number of lanes
//   LW  width of len and of the step counter, $clog2(N+1)
//
// Ports:
//   clk   in   1     clock, all state changes on the rising edge
//   clr   in   1     synchronous active-high reset, highest priority
//   load  in   1     load din into all lanes, latch len, start a countdown
//   len   in   LW    active bits for this load; 0 or >N selects N
//   din   in   C*N   parallel data, lane c in bits [c*N+N-1 : c*N]
//   step  in   1     shift every lane left by one position
//   sin   in   C     serial insert bit per lane, enters bit 0 on a step
//   out   out  C     per-lane tap, out[c] = lane c bit (len_q-1)
//   busy  out  1     countdown in progress (cnt != 0)
//   done  out  1     one-cycle pulse after the last counted step
//   cnt   out  LW    steps remaining in the current countdown
//   dout  out  C*N   all lane registers, din packing (macro only)
// ---------------------------------------------------------------------------
module shiftreg_lanes #(
  parameter int N  = 8,
  parameter int C  = 4,
  parameter int LW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic [LW-1:0]   len,
  input  logic [C*N-1:0]  din,
  input  logic            step,
  input  logic [C-1:0]    sin,
  output logic [C-1:0]    out,
  output logic            busy,
  output logic            done,
  output logic [LW-1:0]   cnt
`ifdef SHIFTREG_LANES_PAROUT_EN
  ,
  output logic [C*N-1:0]  dout
`endif
);

  // -------------------------------------------------------------------------
  // Effective length: a request of 0, or anything wider than the lane,
  // selects the full lane so the tap index always stays in 1..N.
  // -------------------------------------------------------------------------
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] req);
    if (req == '0 || int'(req) > N) begin
      return LW'(N);
    end
    return req;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N-1:0]  lane_q [C];
  logic [N-1:0]  lane_d [C];
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [LW-1:0] load_len;

  assign load_len = eff_len(len);

  // -------------------------------------------------------------------------
  // Next-state logic. Priority below clr (handled in the register process):
  // load > step > hold.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the if/else chain leaves one unassigned, which would infer a latch.
    lane_d = lane_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;

    if (load) begin
      // A simultaneous step is dropped, and any running countdown restarts
      // without a done for the abandoned word.
      for (int c = 0; c < C; c++) begin
        lane_d[c] = din[c*N +: N];
      end
      len_d = load_len;
      cnt_d = load_len;
    end else if (step) begin
      // The whole lane shifts, including bits above len_q: those are
      // don't-care for the tap but still carry data for the parallel view.
      for (int c = 0; c < C; c++) begin
        lane_d[c]    = lane_q[c] << 1;
        lane_d[c][0] = sin[c];
      end
      // Counting only when non-zero keeps cnt from underflowing and makes an
      // idle step behave like the legacy plain shift register.
      if (cnt_q != '0) begin
        cnt_d  = cnt_q - LW'(1);
        done_d = (cnt_q == LW'(1));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the lane array is reset explicitly; it is a small set of flops,
      // not a RAM, and a defined zero state keeps out/dout clean after clr.
      for (int c = 0; c < C; c++) begin
        lane_q[c] <= '0;
      end
      len_q  <= LW'(N);
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int c = 0; c < C; c++) begin
        lane_q[c] <= lane_d[c];
      end
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Tap: out[c] = lane c bit (len_q-1). Written as a compare-per-bit mux so
  // the select never indexes beyond the lane; len_q is always 1..N.
  // -------------------------------------------------------------------------
  always_comb begin
    out = '0;
    for (int c = 0; c < C; c++) begin
      for (int b = 0; b < N; b++) begin
        if (len_q == LW'(b + 1)) begin
          out[c] = lane_q[c][b];
        end
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign cnt  = cnt_q;

`ifdef SHIFTREG_LANES_PAROUT_EN
  // Parallel view of the lanes, packed exactly like din.
  always_comb begin
    dout = '0;
    for (int c = 0; c < C; c++) begin
      dout[c*N +: N] = lane_q[c];
    end
  end
`endif

endmodule
